payload_aligner: RTL and testbench
==================================

Name: payload_aligner

Overview:
- Sits directly downstream of the UDP header parser, between it and the payload consumer.
- Input is the raw 256-bit payload stream. The payload's first beat carries valid bytes starting at lane OFFSET, because the header occupies the lower lanes.
- Output is re-packed so every packet starts at lane 0 and every beat except the last is full (32 bytes).
- Also reports the payload byte length on the last beat.

Parameters:
- OFFSET, 10, lane of the first payload byte in a packet's first input beat; legal range 1..31.
- LEN_W, 16, width of the out_len byte counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  256  payload beat; byte lane i = in_data[8i+7:8i].
- in_keep  input  32  byte enables; keep[i] qualifies lane i.
- in_valid  input  1  beat valid.
- in_last  input  1  last beat of packet.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- out_data  output  256  aligned beat, same lane convention.
- out_keep  output  32  contiguous low-lane mask.
- out_valid  output  1  output beat valid.
- out_last  output  1  last beat of packet.
- out_len  output  LEN_W  total payload bytes; meaningful only when out_valid && out_last, else 0.
- out_ready  input  1  downstream accept.
- fmt_err  output  1  one-cycle pulse on an accepted beat with a malformed keep.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_keep=0, out_data=0, out_len=0, fmt_err=0, state=FIRST, residual cleared.
- Reset mid-packet discards the partial packet; the next accepted beat is treated as a first beat.
- Output stage is a single register: in_ready = (state!=FLUSH) && (!out_valid || out_ready). Latency is 1 cycle from an accepted input beat to the output beat it completes.
- Output holds stable while out_valid && !out_ready.
- Residual register holds R = 32-OFFSET bytes (lanes 0..R-1) plus a residual byte count.
- Legal keep:
  - first beat: contiguous from lane OFFSET upward;
  - middle beats: all ones;
  - last non-first beat: contiguous from lane 0.
  - Any other accepted beat pulses fmt_err; its keep is treated as the popcount-length contiguous mask of the legal form.
- States:
  - FIRST: on accept, n = popcount(keep), in lanes OFFSET..OFFSET+n-1.
    - If !in_last: store those bytes into the residual at lanes 0..n-1, go to STREAM, no output.
    - If in_last && n>0: emit a one-beat packet, data shifted down by OFFSET, keep = (1<<n)-1, out_last=1, out_len=n, stay in FIRST.
    - If in_last && n==0: drop the packet, no output.
  - STREAM, middle beat: emit {in lanes 0..OFFSET-1 at lanes R..31, residual at lanes 0..R-1} with keep=all ones. New residual = in lanes OFFSET..31.
  - STREAM, last beat with m bytes:
    - If m<=OFFSET: emit one beat, keep = (1<<(R+m))-1, out_last=1, go to FIRST.
    - Else: emit a full beat (out_last=0), latch residual = in lanes OFFSET..m-1 (m-OFFSET bytes), go to FLUSH.
  - FLUSH: in_ready=0. When the output register frees, emit the residual with keep=(1<<(m-OFFSET))-1 and out_last=1, then go to FIRST.
- Residual accounting: in STREAM, the residual count on entry is always R. A first beat with n<R is legal only as the last beat. A first beat with n<R and !in_last sets fmt_err and is zero-padded to R.
- out_len: an LEN_W accumulator summing accepted bytes per packet. It saturates at all-ones; it does not wrap. It is cleared on entering FIRST.
- Back-to-back packets: a first beat may be accepted in the same cycle the previous packet's last beat is presented, provided in_ready is high.
- Unused output lanes (keep=0) are driven to 0.

Test Plan:
- OFFSET=10, 3 beats: first keep=0xFFFFFC00 (22 B), middle all ones, last keep=0x000000FF (8 B) -> 2 output beats: full, then keep=0x3FFFFFFF with out_last=1, out_len=62; byte order preserved.
- Last beat keep=0x0000FFFF (16 B), after first(22)+middle(32) -> full, full, then FLUSH beat keep=0x3F with out_last=1, out_len=70; in_ready=0 during FLUSH.
- Single-beat packet: first beat keep=0x0003FC00 with in_last -> one beat, keep=0xFF, out_last=1, out_len=8. Same beat with keep=0 -> no output.
- out_ready held low 5 cycles mid-packet -> out_* stable, in_ready=0, no beat lost or duplicated; random out_ready over 100 packets matches a scoreboard.
- Middle beat keep=0x0000FFFF without in_last -> fmt_err pulses once; stream continues with zero-padded bytes.
- rst_n asserted after the first beat of a packet -> out_valid=0 immediately; next packet aligned correctly from lane 0.

Source files
------------

// File: rtl/payload_aligner.sv
`default_nettype none
// payload_aligner (rev 1.0): re-packs a header-offset 256-bit payload stream so every packet
// starts at lane 0 with full beats, and reports the payload byte length on the last beat.
module payload_aligner #(
  parameter int OFFSET = 10,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [255:0]     in_data,
  input  logic [31:0]      in_keep,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [255:0]     out_data,
  output logic [31:0]      out_keep,
  output logic             out_valid,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  input  logic             out_ready,
  output logic             fmt_err
);
  localparam int         c_R     = 32 - OFFSET;
  localparam logic [5:0] c_R6    = 6'(c_R);
  localparam logic [5:0] c_OFF6  = 6'(OFFSET);
  localparam logic [1:0] S_FIRST = 2'd0, S_STREAM = 2'd1, S_FLUSH = 2'd2;

  function automatic logic [5:0] popcnt(input logic [31:0] k);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, k[i]};
    return c;
  endfunction

  function automatic logic [31:0] lowmask(input logic [5:0] n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  function automatic logic [255:0] bytemask(input logic [31:0] m);
    logic [255:0] e;
    for (int i = 0; i < 32; i++) e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [5:0] b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-5){1'b0}}, b};
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  logic [1:0]       r_state, w_state_nx;
  logic [c_R*8-1:0] r_res, w_res_nx;
  logic [5:0]       r_flush_n;
  logic [LEN_W-1:0] r_acc, w_acc_nx;
  logic [255:0]     r_out_data, w_nx_data, w_din;
  logic [31:0]      r_out_keep, w_nx_keep, w_mask;
  logic             r_out_valid, r_out_last, r_fmt_err;
  logic [LEN_W-1:0] r_out_len, w_nx_len;
  logic [5:0]       w_cnt, w_n_first;
  logic             w_free, w_accept, w_bad, w_cnt_le_off, w_emit, w_nx_last, w_res_ld;

  assign w_free       = !r_out_valid || out_ready;
  assign in_ready     = (r_state != S_FLUSH) && w_free;
  assign w_accept     = in_valid && in_ready;
  assign w_cnt        = popcnt(in_keep);
  assign w_n_first    = (w_cnt > c_R6) ? c_R6 : w_cnt;
  assign w_cnt_le_off = (w_cnt <= c_OFF6);
  // A malformed keep is replaced by the legal mask of the same popcount for this beat type.
  assign w_mask = (r_state == S_FIRST) ? (lowmask(w_n_first) << OFFSET) : lowmask(w_cnt);
  assign w_din  = in_data & bytemask(w_mask);
  assign w_bad  = (r_state == S_FIRST) ? ((in_keep != w_mask) || (!in_last && (w_cnt != c_R6)))
                : (!in_last)           ? (w_cnt != 6'd32)
                :                        (in_keep != w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FIRST;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_FIRST:  if (w_accept && !in_last) w_state_nx = S_STREAM;
      S_STREAM: if (w_accept && in_last) w_state_nx = w_cnt_le_off ? S_FIRST : S_FLUSH;
      S_FLUSH:  if (w_free) w_state_nx = S_FIRST;
      default:  w_state_nx = S_FIRST;
    endcase
  end

  always_comb begin
    w_emit    = 1'b0;
    w_nx_data = '0;
    w_nx_keep = '0;
    w_nx_last = 1'b0;
    w_nx_len  = '0;
    w_res_ld  = 1'b0;
    w_res_nx  = w_din[255:OFFSET*8];
    w_acc_nx  = r_acc;
    case (r_state)
      S_FIRST: if (w_accept) begin
        if (!in_last) begin
          w_res_ld = 1'b1;
          w_acc_nx = sat_add('0, c_R6);
        end else if (w_n_first != 6'd0) begin
          w_emit    = 1'b1;
          w_nx_data = {{(OFFSET*8){1'b0}}, w_din[255:OFFSET*8]};
          w_nx_keep = lowmask(w_n_first);
          w_nx_last = 1'b1;
          w_nx_len  = sat_add('0, w_n_first);
        end
      end
      S_STREAM: if (w_accept) begin
        w_emit    = 1'b1;
        w_nx_data = {w_din[OFFSET*8-1:0], r_res};
        if (!in_last) begin
          w_nx_keep = '1;
          w_res_ld  = 1'b1;
          w_acc_nx  = sat_add(r_acc, 6'd32);
        end else if (w_cnt_le_off) begin
          w_nx_keep = lowmask(c_R6 + w_cnt);
          w_nx_last = 1'b1;
          w_nx_len  = sat_add(r_acc, w_cnt);
          w_acc_nx  = '0;
        end else begin
          w_nx_keep = '1;
          w_res_ld  = 1'b1;
          w_acc_nx  = sat_add(r_acc, w_cnt);
        end
      end
      S_FLUSH: if (w_free) begin
        w_emit    = 1'b1;
        w_nx_data = {{(OFFSET*8){1'b0}}, r_res};
        w_nx_keep = lowmask(r_flush_n);
        w_nx_last = 1'b1;
        w_nx_len  = r_acc;
        w_acc_nx  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_flush_n   <= '0;
      r_acc       <= '0;
      r_fmt_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= '0;
      r_out_data  <= '0;
      r_out_len   <= '0;
    end else begin
      r_fmt_err <= w_accept && w_bad;
      r_acc     <= w_acc_nx;
      if (w_res_ld) r_res <= w_res_nx;
      if (w_res_ld && in_last) r_flush_n <= w_cnt - c_OFF6;
      // Reloading with zeros when nothing is emitted keeps idle lanes and out_len at 0.
      if (w_free) begin
        r_out_valid <= w_emit;
        r_out_last  <= w_nx_last;
        r_out_keep  <= w_nx_keep;
        r_out_data  <= w_nx_data;
        r_out_len   <= w_nx_len;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_len   = r_out_len;
  assign fmt_err   = r_fmt_err;
endmodule
`default_nettype wire

// File: tb/tb_payload_aligner.sv
`default_nettype none
// tb_payload_aligner: randomized and directed packets scored against a byte-queue model.
module tb_payload_aligner;
  localparam int OFF = 10;
  localparam int R   = 32 - OFF;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [255:0]  in_data = '0;
  logic [31:0]   in_keep = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [255:0]  out_data;
  logic [31:0]   out_keep;
  logic          out_valid, out_last, fmt_err;
  logic [LW-1:0] out_len;
  logic          out_ready = 1'b1;
  int            rdy_mode = 0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0]  exp_data[$];
  logic [31:0]   exp_keep[$];
  logic          exp_last[$];
  logic [LW-1:0] exp_len[$];
  logic          exp_fmt[$];
  logic [31:0]   pk_keep[16];

  payload_aligner #(.OFFSET(OFF), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
    .out_len(out_len), .out_ready(out_ready), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lowmask(input int n);
    return (n >= 32) ? 32'hFFFFFFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 2) out_ready = 1'b0;
    else                    out_ready = ($urandom_range(0, 3) != 0);
  end

  logic          prev_acc = 1'b0, prev_stall = 1'b0;
  logic [255:0]  snap_data;
  logic [31:0]   snap_keep;
  logic          snap_last;
  logic [LW-1:0] snap_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_acc) begin
        if (exp_fmt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fmt_queue: got accepted beat expected none outstanding");
        end else chk("fmt_err", fmt_err, exp_fmt.pop_front());
      end else chk("fmt_idle", fmt_err, 0);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, snap_data);
        chk("hold_keep", out_keep, snap_keep);
        chk("hold_last", out_last, snap_last);
        chk("hold_len", out_len, snap_len);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got keep %h expected no beat", out_keep);
        end else begin
          chk("out_data", out_data, exp_data.pop_front());
          chk("out_keep", out_keep, exp_keep.pop_front());
          chk("out_last", out_last, exp_last.pop_front());
          chk("out_len", out_len, exp_len.pop_front());
        end
      end
      if (!out_valid) chk("idle_len", out_len, 0);
      prev_acc   = in_valid && in_ready;
      prev_stall = out_valid && !out_ready;
      snap_data  = out_data;
      snap_keep  = out_keep;
      snap_last  = out_last;
      snap_len   = out_len;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be entered just after a posedge; returns just after the accepting posedge.
  task automatic put_beat(input logic [31:0] k, input logic [255:0] d, input logic l, input logic bad);
    int guard;
    exp_fmt.push_back(bad);
    in_keep = k; in_data = d; in_last = l; in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 2000 cycles");
        break;
      end
      @(negedge clk);
    end
    sync();
    in_valid = 1'b0; in_last = 1'b0; in_keep = '0; in_data = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_data.size() != 0 || out_valid) && guard < 3000) begin
      sync();
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_data.size());
    end
    sync();
  endtask

  // Model: gather the packet's payload bytes in order (with zero padding for malformed
  // beats), then cut the byte stream into 32-byte output beats.
  task automatic send_packet(input int nb);
    byte unsigned bq[$];
    logic [255:0] d[16];
    logic         bad[16];
    int           cnt, n, total, pos, take;
    logic [255:0] od;
    logic [31:0]  ok;
    for (int b = 0; b < nb; b++) begin
      bit l;
      l = (b == nb - 1);
      for (int w = 0; w < 8; w++) d[b][32*w +: 32] = $urandom;
      cnt = $countones(pk_keep[b]);
      if (b == 0) begin
        n = (cnt > R) ? R : cnt;
        bad[b] = (pk_keep[b] != (lowmask(n) << OFF)) || (!l && cnt != R);
        for (int i = 0; i < R; i++)
          if (i < n) bq.push_back(d[b][8*(OFF+i) +: 8]);
          else if (!l) bq.push_back(8'h00);
      end else if (!l) begin
        bad[b] = (pk_keep[b] != 32'hFFFFFFFF);
        for (int i = 0; i < 32; i++) bq.push_back(i < cnt ? d[b][8*i +: 8] : 8'h00);
      end else begin
        bad[b] = (pk_keep[b] != lowmask(cnt));
        for (int i = 0; i < cnt; i++) bq.push_back(d[b][8*i +: 8]);
      end
    end
    total = bq.size();
    pos = 0;
    while (pos < total) begin
      take = (total - pos > 32) ? 32 : total - pos;
      od = '0; ok = '0;
      for (int i = 0; i < take; i++) begin
        od[8*i +: 8] = bq[pos+i];
        ok[i] = 1'b1;
      end
      pos += take;
      exp_data.push_back(od);
      exp_keep.push_back(ok);
      exp_last.push_back(pos == total);
      exp_len.push_back(pos == total ? LW'(total) : LW'(0));
    end
    for (int b = 0; b < nb; b++) put_beat(pk_keep[b], d[b], b == nb - 1, bad[b]);
    if (nb > 1 && $countones(pk_keep[nb-1]) > OFF) begin
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      sync();
    end
  endtask

  task automatic rand_packet();
    int nb;
    nb = $urandom_range(1, 5);
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 9) == 0) pk_keep[b] = $urandom;
      else if (b == 0) pk_keep[b] = (nb == 1) ? (lowmask($urandom_range(0, R)) << OFF) : (lowmask(R) << OFF);
      else if (b != nb - 1) pk_keep[b] = 32'hFFFFFFFF;
      else pk_keep[b] = lowmask($urandom_range(0, 32));
    end
    send_packet(nb);
  endtask

  initial begin
    logic [255:0] rd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_fmt_err", fmt_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    sync();

    rdy_mode = 0;
    pk_keep[0] = 32'hFFFFFC00; pk_keep[1] = 32'hFFFFFFFF; pk_keep[2] = 32'h000000FF;
    send_packet(3);
    pk_keep[2] = 32'h0000FFFF;
    send_packet(3);
    pk_keep[0] = 32'h0003FC00;
    send_packet(1);
    pk_keep[0] = 32'h00000000;
    send_packet(1);
    pk_keep[0] = 32'hFFFFFC00; pk_keep[1] = 32'h0000FFFF; pk_keep[2] = 32'hFFFFFFFF; pk_keep[3] = 32'h0000000F;
    send_packet(4);
    drain();

    pk_keep[0] = 32'hFFFFFC00; pk_keep[1] = 32'hFFFFFFFF; pk_keep[2] = 32'hFFFFFFFF; pk_keep[3] = 32'h0000FFFF;
    fork
      send_packet(4);
      begin
        repeat (2) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    put_beat(32'hFFFFFC00, rd, 1'b0, 1'b0);
    rdy_mode = 2;
    put_beat(32'hFFFFFFFF, ~rd, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_keep", out_keep, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_len", out_len, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    exp_fmt.delete();
    rst_n = 1'b1;
    rdy_mode = 1;
    sync();

    repeat (100) rand_packet();
    rdy_mode = 0;
    drain();
    chk("scoreboard_empty", exp_data.size(), 0);
    chk("fmt_queue_empty", exp_fmt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
